// File: rtl/rom_stream_reader_pkg.sv
// Shared types and constants for the coefficient-ROM stream reader.
package rom_reader_pkg;

  localparam int unsigned ROM_AW = 8;
  localparam int unsigned ROM_DW = 40;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  // One buffered word plus its end-of-transfer marker.
  typedef struct packed {
    logic              last;
    logic [ROM_DW-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/rom_stream_reader_if.sv
// Valid/ready word stream carrying ROM words and an end-of-transfer marker.
interface rom_stream_reader_if
  import rom_reader_pkg::*;
#(
  parameter int unsigned DW = ROM_DW
);

  logic          valid;
  logic          ready;
  logic [DW-1:0] data;
  logic          last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; push and pop may coincide even when full.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [Width-1:0]           data_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           data_o,
  output logic                       empty_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Qualify push/pop and compute next pointers and occupancy.
  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && ((count_q != CntW'(Depth)) || do_pop);
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CntW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CntW'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is cleared on reset so the head word reads as zero afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Head word and status outputs.
  always_comb begin
    data_o  = mem_q[rd_ptr_q];
    empty_o = (count_q == '0);
    count_o = count_q;
  end

endmodule

// File: rtl/rom_stream_reader.sv
// Sequences reads from a registered-output ROM and streams the words out with backpressure.
module rom_stream_reader
  import rom_reader_pkg::*;
#(
  parameter int unsigned AW    = ROM_AW,
  parameter int unsigned DW    = ROM_DW,
  parameter int unsigned DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_i,
  input  logic [AW-1:0]       base_i,
  input  logic [AW:0]         count_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [AW-1:0]       rom_a_o,
  output logic                rom_cen_o,
  input  logic [DW-1:0]       rom_q_i,
  rom_stream_reader_if.master out_if
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  state_e          state_q, state_d;
  logic [AW-1:0]   base_q, base_d;
  logic [AW:0]     count_q, count_d;
  logic [AW:0]     issue_idx_q, issue_idx_d;
  logic [AW-1:0]   rom_a_q, rom_a_d;
  logic            inflight_q, inflight_d;
  logic            last_q, last_d;
  logic [CntW-1:0] fifo_count;
  logic            fifo_empty;
  logic            fifo_pop;
  logic [DW:0]     fifo_rdata;
  logic [31:0]     occupancy;
  logic            final_issue;
  logic            accept;

  // Issue decode uses registers only, so out_ready never reaches the ROM pins.
  always_comb begin
    occupancy   = 32'(fifo_count) + 32'(inflight_q);
    rom_cen_o   = (state_q == StRun) && (occupancy < DEPTH);
    final_issue = (issue_idx_q == count_q - (AW+1)'(1));
    rom_a_o     = rom_cen_o ? base_q + issue_idx_q[AW-1:0] : rom_a_q;
    accept      = (state_q == StIdle) && start_i;
    fifo_pop    = out_if.valid && out_if.ready;
    busy_o      = (state_q != StIdle);
    done_o      = (state_q == StDone);
  end

  // Transfer sequencing; DRAIN exits when the last word leaves on this edge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = (count_i == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (rom_cen_o && final_issue) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (!inflight_q &&
            ((fifo_count == '0) || ((fifo_count == CntW'(1)) && fifo_pop))) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Transfer parameters, read index and the one-deep read pipeline tracker.
  always_comb begin
    base_d      = accept ? base_i : base_q;
    count_d     = accept ? count_i : count_q;
    issue_idx_d = issue_idx_q;
    if (accept) begin
      issue_idx_d = '0;
    end else if (rom_cen_o) begin
      issue_idx_d = issue_idx_q + (AW+1)'(1);
    end
    rom_a_d    = rom_cen_o ? rom_a_o : rom_a_q;
    inflight_d = rom_cen_o;
    last_d     = rom_cen_o && final_issue;
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      base_q      <= '0;
      count_q     <= '0;
      issue_idx_q <= '0;
      rom_a_q     <= '0;
      inflight_q  <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      count_q     <= count_d;
      issue_idx_q <= issue_idx_d;
      rom_a_q     <= rom_a_d;
      inflight_q  <= inflight_d;
      last_q      <= last_d;
    end
  end

  // ROM data lands here one cycle after its read; the issue rule guarantees room.
  sync_fifo #(
    .Width(DW + 1),
    .Depth(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (inflight_q),
    .data_i ({last_q, rom_q_i}),
    .pop_i  (fifo_pop),
    .data_o (fifo_rdata),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  // Stream side is presented straight from the FIFO head.
  always_comb begin
    out_if.valid = !fifo_empty;
    out_if.last  = fifo_rdata[DW];
    out_if.data  = fifo_rdata[DW-1:0];
  end

endmodule

// File: tb/tb_rom_stream_reader.sv
// Scoreboarded bench: stimulus queues expected reads/words, monitor compares on handshakes.
module tb_rom_stream_reader;
  import rom_reader_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  base = '0;
  logic [8:0]  count = '0;
  logic        busy, done, rom_cen;
  logic [7:0]  rom_a;
  logic [39:0] rom_q;

  rom_stream_reader_if #(.DW(ROM_DW)) out_if ();

  rom_stream_reader #(
    .AW   (ROM_AW),
    .DW   (ROM_DW),
    .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start_i  (start),
    .base_i   (base),
    .count_i  (count),
    .busy_o   (busy),
    .done_o   (done),
    .rom_a_o  (rom_a),
    .rom_cen_o(rom_cen),
    .rom_q_i  (rom_q),
    .out_if   (out_if)
  );

  logic [39:0] rom_mem [256];
  fifo_entry_t exp_q [$];
  logic [7:0]  addr_q [$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          ready_mode = 0;
  int          first_valid_cyc = -1;
  int          issued = 0;
  int          delivered = 0;
  bit          stall_prev = 1'b0;
  fifo_entry_t prev_word;
  bit          pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered-output ROM: Q holds while cen is low.
  always @(posedge clk) if (rom_cen) rom_q <= rom_mem[rom_a];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail(input string name, input logic [63:0] act);
    n_checks++;
    $display("FAIL %s: got %0h, expected nothing (cycle %0d)", name, act, cyc);
  endtask

  task automatic flush();
    exp_q.delete();
    addr_q.delete();
    issued     = 0;
    delivered  = 0;
    stall_prev = 1'b0;
  endtask

  // Reference model: a transfer is just base+i (mod 256) for i in 0..count-1.
  task automatic enqueue(input logic [7:0] b, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      fifo_entry_t e;
      e.last = (i == cnt - 1);
      e.data = rom_mem[8'(int'(b) + i)];
      exp_q.push_back(e);
      addr_q.push_back(8'(int'(b) + i));
    end
  endtask

  // Downstream ready: 0 = always, 1 = fixed 1,0,0,1,0,1 pattern, 2 = random.
  initial begin
    out_if.ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_if.ready = 1'b1;
        1:       out_if.ready = pat[cyc % 6];
        default: out_if.ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: ROM address order, outstanding-read bound, stall stability, word order.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        stall_prev = 1'b0;
      end else begin
        if (rom_cen) begin
          if (addr_q.size() == 0) fail("unexpected_rom_read", 64'(rom_a));
          else check("rom_addr", 64'(rom_a), 64'(addr_q.pop_front()));
          issued++;
          check("outstanding_le_depth", 64'((issued - delivered) <= DEPTH), 64'(1));
        end
        if (stall_prev) begin
          check("valid_held", 64'(out_if.valid), 64'(1));
          check("word_held", 64'({out_if.last, out_if.data}), 64'(prev_word));
        end
        if (out_if.valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (out_if.valid && out_if.ready) begin
          if (exp_q.size() == 0) fail("unexpected_word", 64'({out_if.last, out_if.data}));
          else check("out_word", 64'({out_if.last, out_if.data}), 64'(exp_q.pop_front()));
          delivered++;
        end
        stall_prev = out_if.valid && !out_if.ready;
        prev_word  = {out_if.last, out_if.data};
      end
    end
  end

  task automatic run_xfer(input logic [7:0] b, input int cnt, input int mode, input bit inject);
    int  t0;
    bit  seen_done;
    ready_mode = mode;
    enqueue(b, cnt);
    @(negedge clk);
    first_valid_cyc = -1;
    start = 1'b1;
    base  = b;
    count = 9'(cnt);
    t0    = cyc;
    @(negedge clk);
    start = 1'b0;
    check("busy_cycle1", 64'(busy), 64'(1));
    if (inject) begin
      @(negedge clk);
      start = 1'b1;
      base  = 8'(int'(b) + 7);
      count = 9'd5;
      @(negedge clk);
      start = 1'b0;
    end
    seen_done = 1'b0;
    for (int k = 0; k < 3000 && !seen_done; k++) begin
      if (done) seen_done = 1'b1;
      else @(negedge clk);
    end
    check("done_seen", 64'(seen_done), 64'(1));
    if (seen_done) begin
      if (mode == 0) check("done_cycle", 64'(cyc - t0), 64'((cnt == 0) ? 1 : cnt + 3));
      if (mode == 0 && cnt > 0) check("first_valid_cycle", 64'(first_valid_cyc - t0), 64'(3));
      check("words_left", 64'(exp_q.size()), 64'(0));
      check("reads_left", 64'(addr_q.size()), 64'(0));
      @(negedge clk);
      check("busy_after", 64'(busy), 64'(0));
      check("done_one_cycle", 64'(done), 64'(0));
    end
    flush();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_rom_cen"}, 64'(rom_cen), 64'(0));
    check({tag, "_rom_a"}, 64'(rom_a), 64'(0));
    check({tag, "_out_valid"}, 64'(out_if.valid), 64'(0));
    check({tag, "_out_data"}, 64'(out_if.data), 64'(0));
    check({tag, "_out_last"}, 64'(out_if.last), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb;
    for (int i = 0; i < 256; i++) rom_mem[i] = {8'($urandom), 32'($urandom)};
    rom_mem[0] = 40'h1851030000;
    rom_mem[3] = 40'h2c50c37230;

    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    reset = 1'b0;

    run_xfer(8'd0, 4, 0, 1'b0);
    run_xfer(8'd254, 4, 0, 1'b0);
    run_xfer(8'($urandom), 3, 1, 1'b0);
    run_xfer(8'($urandom), 0, 0, 1'b0);

    // Reset in cycle 5 of a long transfer, then restart from the same base.
    rb = 8'($urandom);
    ready_mode = 0;
    enqueue(rb, 100);
    @(negedge clk);
    start = 1'b1;
    base  = rb;
    count = 9'd100;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    flush();
    check_idle_outputs("midreset");
    repeat (5) begin
      @(negedge clk);
      check("no_done_after_reset", 64'(done), 64'(0));
    end
    run_xfer(rb, 10, 0, 1'b0);

    run_xfer(8'($urandom), 6, 0, 1'b1);
    for (int t = 0; t < 8; t++) begin
      run_xfer(8'($urandom), int'($urandom_range(1, 40)), 2, 1'b0);
    end
    run_xfer(8'($urandom), 256, 2, 1'b0);
    run_xfer(8'($urandom), 1, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
